norm_round_pack_r4: RTL

NORM_ROUND_PACK_R4 -- requirements
Module: norm_round_pack_r4

---
 rtl/norm_round_pack_r4.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/norm_round_pack_r4.sv
// norm_round_pack_r4
// Normalizes, rounds and packs a wide adder sum into an IEEE-754 single-precision result.
// One operation in flight: IDLE accepts, NORM normalizes, ROUND rounds/packs, HOLD presents.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (ready only in IDLE)
//   kill              flush the in-flight operation, back to IDLE
//   rm                rounding mode (RNE, RTZ, RDN, RUP, RMM; reserved codes act as RNE)
//   res_sign          sign of the sum
//   exp_in            signed biased exponent of the sum
//   mant_sum          sum magnitude, bit 46 has weight 1.0
//   sticky_in         OR of bits lost during alignment
//   zero_sign         sign of an exact-zero result
//   is_nan, invalid   NaN result and NV flag
//   is_inf, inf_sign  infinite result and its sign
//   out_valid/out_ready result handshake (valid only in HOLD)
//   result, fflags    packed result and {NV,DZ,OF,UF,NX}

module norm_round_pack_r4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        kill,
    input  logic [2:0]  rm,
    input  logic        res_sign,
    input  logic [9:0]  exp_in,
    input  logic [48:0] mant_sum,
    input  logic        sticky_in,
    input  logic        zero_sign,
    input  logic        is_nan,
    input  logic        invalid,
    input  logic        is_inf,
    input  logic        inf_sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  fflags
);

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StHold} state_e;

    typedef struct packed {
        logic [2:0]  rm;
        logic        sign;
        logic [9:0]  exp;
        logic [48:0] mant;
        logic        sticky;
        logic        zero_sign;
        logic        nan;
        logic        invalid;
        logic        inf;
        logic        inf_sign;
    } op_t;

    state_e      state_q, state_d;
    op_t         op_q, op_d;
    logic [46:0] nmant_q, nmant_d;
    logic [9:0]  nexp_q, nexp_d;
    logic        nsticky_q, nsticky_d;
    logic        tiny_q, tiny_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  fflags_q, fflags_d;

    // ---------------- control ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StNorm;
            StNorm:  state_d = StRound;
            StRound: state_d = StHold;
            StHold:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (kill) state_d = StIdle;
    end

    always_comb begin
        op_d = op_q;
        if (state_q == StIdle && in_valid) begin
            op_d = '{rm: rm, sign: res_sign, exp: exp_in, mant: mant_sum, sticky: sticky_in,
                     zero_sign: zero_sign, nan: is_nan, invalid: invalid, inf: is_inf,
                     inf_sign: inf_sign};
        end
    end

    // ---------------- normalize ----------------
    logic [5:0]  lead;
    logic [9:0]  e_norm;
    logic [95:0] sh_norm;
    logic [95:0] sh_tiny;
    logic [46:0] m_norm;
    logic        tiny;
    logic [10:0] rsh_wide;
    logic [5:0]  rsh;

    always_comb begin
        lead = '0;
        for (int i = 0; i < 49; i++) begin
            if (op_q.mant[i]) lead = 6'(i);
        end
        e_norm = op_q.exp + {4'b0, lead} - 10'd46;

        // Lower 49 bits of each wide shift collect what falls off the bottom.
        // Bits above 46 are always zero after normalization, so the top is truncated.
        if (lead >= 6'd46) begin
            sh_norm = 96'({op_q.mant, 49'b0} >> (lead - 6'd46));
        end else begin
            sh_norm = 96'({op_q.mant << (6'd46 - lead), 49'b0});
        end
        m_norm = sh_norm[95:49];

        tiny     = $signed(e_norm) <= 10'sd0;
        rsh_wide = 11'd1 - {e_norm[9], e_norm};
        rsh      = (rsh_wide > 11'd48) ? 6'd48 : rsh_wide[5:0];
        sh_tiny  = tiny ? ({m_norm, 49'b0} >> rsh) : {m_norm, 49'b0};

        nmant_d   = nmant_q;
        nexp_d    = nexp_q;
        nsticky_d = nsticky_q;
        tiny_d    = tiny_q;
        if (state_q == StNorm) begin
            nmant_d   = sh_tiny[95:49];
            nexp_d    = tiny ? 10'd0 : e_norm;
            nsticky_d = op_q.sticky | (|sh_norm[48:0]) | (|sh_tiny[48:0]);
            tiny_d    = tiny;
            // Zero magnitude with sticky: the smallest value below the subnormal range.
            if (op_q.mant == '0) begin
                nmant_d   = '0;
                nexp_d    = 10'd0;
                nsticky_d = op_q.sticky;
                tiny_d    = 1'b1;
            end
        end
    end

    // ---------------- round and pack ----------------
    logic [23:0] sig;
    logic        g, s, inc, nx, ovf, to_inf;
    logic [24:0] sum;
    logic [9:0]  exp_r;
    logic [22:0] frac;
    logic [31:0] rounded;
    logic [4:0]  rflags;

    always_comb begin
        sig = nmant_q[46:23];
        g   = nmant_q[22];
        s   = (|nmant_q[21:0]) | nsticky_q;
        unique case (op_q.rm)
            3'b001:  inc = 1'b0;
            3'b010:  inc = op_q.sign & (g | s);
            3'b011:  inc = ~op_q.sign & (g | s);
            3'b100:  inc = g;
            default: inc = g & (s | sig[0]);
        endcase
        unique case (op_q.rm)
            3'b001:  to_inf = 1'b0;
            3'b010:  to_inf = op_q.sign;
            3'b011:  to_inf = ~op_q.sign;
            default: to_inf = 1'b1;
        endcase

        sum   = {1'b0, sig} + {24'b0, inc};
        exp_r = nexp_q;
        frac  = sum[22:0];
        if (sum[24]) begin
            exp_r = nexp_q + 10'd1;
            frac  = sum[23:1];
        end else if (tiny_q && sum[23]) begin
            exp_r = 10'd1;  // subnormal rounded up into the normal range
        end
        nx  = g | s;
        ovf = $signed(exp_r) >= 10'sd255;

        if (ovf) begin
            rounded = to_inf ? {op_q.sign, 8'hFF, 23'b0} : {op_q.sign, 31'h7F7F_FFFF};
            rflags  = 5'b00101;
        end else begin
            rounded = {op_q.sign, exp_r[7:0], frac};
            rflags  = {3'b000, tiny_q & nx, nx};
        end

        result_d = result_q;
        fflags_d = fflags_q;
        if (state_q == StRound && !kill) begin
            if (op_q.nan) begin
                result_d = 32'h7FC0_0000;
                fflags_d = {op_q.invalid, 4'b0};
            end else if (op_q.inf) begin
                result_d = {op_q.inf_sign, 8'hFF, 23'b0};
                fflags_d = {op_q.invalid, 4'b0};
            end else if (op_q.mant == '0 && !op_q.sticky) begin
                result_d = {op_q.zero_sign, 31'b0};
                fflags_d = 5'b0;
            end else begin
                result_d = rounded;
                fflags_d = rflags;
            end
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            nmant_q   <= '0;
            nexp_q    <= '0;
            nsticky_q <= 1'b0;
            tiny_q    <= 1'b0;
            result_q  <= '0;
            fflags_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            nmant_q   <= nmant_d;
            nexp_q    <= nexp_d;
            nsticky_q <= nsticky_d;
            tiny_q    <= tiny_d;
            result_q  <= result_d;
            fflags_q  <= fflags_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StHold);
    assign result    = result_q;
    assign fflags    = fflags_q;

endmodule
